// File: rtl/alu_share_arb.sv
// Two-requester arbiter/sequencer that time-shares one combinational ALU.
// Each request is granted, executed for one cycle, and its result is held until the requester takes it.
module alu_share_arb #(
  parameter bit RR_EN  = 1'b1,
  parameter int OP_W   = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_src1,
  input  logic [DATA_W-1:0] req0_src2,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp0_err,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_src1,
  input  logic [DATA_W-1:0] req1_src2,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp1_err,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_src1,
  output logic [DATA_W-1:0] alu_src2,
  input  logic [DATA_W-1:0] alu_result,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]        state;
  logic              last_grant;
  logic              gnt_id;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] src1_q;
  logic [DATA_W-1:0] src2_q;
  logic [DATA_W-1:0] result_q;
  logic              err_q;

  logic              arb_id;
  logic              accept;
  logic              rsp_fire;
  logic [OP_W-1:0]   sel_op;
  logic [DATA_W-1:0] sel_src1;
  logic [DATA_W-1:0] sel_src2;

  // NOTE: arb_id gets a default before any branch so always_comb never infers a latch.
  always_comb begin
    arb_id = 1'b0;
    if (req0_valid && req1_valid) begin
      arb_id = RR_EN ? ~last_grant : 1'b0;
    end else if (req1_valid) begin
      arb_id = 1'b1;
    end
  end

  // Ready depends only on state and the valids, never the other way round.
  assign accept     = (state == ST_IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept && !arb_id;
  assign req1_ready = accept && arb_id;

  assign sel_op   = arb_id ? req1_op   : req0_op;
  assign sel_src1 = arb_id ? req1_src1 : req0_src1;
  assign sel_src2 = arb_id ? req1_src2 : req0_src2;

  assign rsp_fire = (state == ST_RESP) && (gnt_id ? rsp1_ready : rsp0_ready);

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  // NOTE: operand/result registers are reset as well, since they drive alu_src* and rsp* directly.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      gnt_id     <= 1'b0;
      op_q       <= '0;
      src1_q     <= '0;
      src2_q     <= '0;
      result_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q       <= sel_op;
            src1_q     <= sel_src1;
            src2_q     <= sel_src2;
            gnt_id     <= arb_id;
            last_grant <= arb_id;
            if ($onehot(sel_op)) begin
              state <= ST_EXEC;
            end else begin
              // Illegal op never reaches the ALU; answer directly with an error.
              result_q <= '0;
              err_q    <= 1'b1;
              state    <= ST_RESP;
            end
          end
        end
        ST_EXEC: begin
          result_q <= alu_result;
          err_q    <= 1'b0;
          state    <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_fire) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign alu_op   = (state == ST_EXEC) ? op_q : '0;
  assign alu_src1 = src1_q;
  assign alu_src2 = src2_q;

  assign rsp0_valid  = (state == ST_RESP) && !gnt_id;
  assign rsp1_valid  = (state == ST_RESP) && gnt_id;
  assign rsp0_result = rsp0_valid ? result_q : '0;
  assign rsp1_result = rsp1_valid ? result_q : '0;
  assign rsp0_err    = rsp0_valid && err_q;
  assign rsp1_err    = rsp1_valid && err_q;

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_alu_share_arb.sv
// Scoreboard bench for alu_share_arb: round-robin instance fully checked, a fixed-priority
// instance shares the requester inputs and is checked for grant order.
module tb_alu_share_arb;
  localparam int OP_W   = 12;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic              req0_valid, req1_valid, rsp0_ready, rsp1_ready;
  logic [OP_W-1:0]   req0_op, req1_op;
  logic [DATA_W-1:0] req0_src1, req0_src2, req1_src1, req1_src2;

  logic              req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, busy;
  logic [DATA_W-1:0] rsp0_result, rsp1_result, alu_src1, alu_src2, alu_result;
  logic [OP_W-1:0]   alu_op;

  logic              b_req0_ready, b_req1_ready, b_rsp0_valid, b_rsp1_valid, b_rsp0_err, b_rsp1_err, b_busy;
  logic [DATA_W-1:0] b_rsp0_result, b_rsp1_result, b_alu_src1, b_alu_src2, b_alu_result;
  logic [OP_W-1:0]   b_alu_op;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic              err;
  } exp_t;

  exp_t exp0[$];
  exp_t exp1[$];

  // Environment ALU: one bit per operation.
  function automatic logic [DATA_W-1:0] alu_fn(input logic [OP_W-1:0] op,
                                               input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    case (op)
      12'h001: return a + b;
      12'h002: return a - b;
      12'h004: return a & b;
      12'h008: return a | b;
      12'h010: return a ^ b;
      12'h020: return a << b[4:0];
      12'h040: return a >> b[4:0];
      12'h080: return DATA_W'($signed(a) >>> b[4:0]);
      12'h100: return {31'd0, $signed(a) < $signed(b)};
      12'h200: return {31'd0, a < b};
      12'h400: return b;
      12'h800: return ~a;
      default: return '0;
    endcase
  endfunction

  function automatic exp_t model(input logic [OP_W-1:0] op,
                                 input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    exp_t e;
    if ($countones(op) == 1) begin
      e.res = alu_fn(op, a, b);
      e.err = 1'b0;
    end else begin
      e.res = '0;
      e.err = 1'b1;
    end
    return e;
  endfunction

  assign alu_result   = alu_fn(alu_op, alu_src1, alu_src2);
  assign b_alu_result = alu_fn(b_alu_op, b_alu_src1, b_alu_src2);

  alu_share_arb #(.RR_EN(1'b1), .OP_W(OP_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .resetn(resetn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_src1(req0_src1), .req0_src2(req0_src2),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_src1(req1_src1), .req1_src2(req1_src2),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_err(rsp1_err),
    .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_result(alu_result),
    .busy(busy)
  );

  alu_share_arb #(.RR_EN(1'b0), .OP_W(OP_W), .DATA_W(DATA_W)) dut_fixed (
    .clk(clk), .resetn(resetn),
    .req0_valid(req0_valid), .req0_ready(b_req0_ready), .req0_op(req0_op),
    .req0_src1(req0_src1), .req0_src2(req0_src2),
    .rsp0_valid(b_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(b_rsp0_result), .rsp0_err(b_rsp0_err),
    .req1_valid(req1_valid), .req1_ready(b_req1_ready), .req1_op(req1_op),
    .req1_src1(req1_src1), .req1_src2(req1_src2),
    .rsp1_valid(b_rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(b_rsp1_result), .rsp1_err(b_rsp1_err),
    .alu_op(b_alu_op), .alu_src1(b_alu_src1), .alu_src2(b_alu_src2), .alu_result(b_alu_result),
    .busy(b_busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
  endtask

  function automatic logic [OP_W-1:0] rand_op();
    if ($urandom % 4 == 0) return OP_W'($urandom);
    return OP_W'(1) << ($urandom % OP_W);
  endfunction

  function automatic logic [DATA_W-1:0] rand_data();
    if ($urandom % 8 == 0) return '1;
    if ($urandom % 8 == 0) return '0;
    return $urandom;
  endfunction

  // Scoreboard monitor: push expectations at request handshakes, pop at response handshakes.
  always @(negedge clk) begin
    exp_t e;
    if (!resetn) begin
      exp0.delete();
      exp1.delete();
    end else begin
      if (req0_valid && req0_ready) exp0.push_back(model(req0_op, req0_src1, req0_src2));
      if (req1_valid && req1_ready) exp1.push_back(model(req1_op, req1_src1, req1_src2));
      if (req0_ready || req1_ready) check("ready_exclusive", {req0_ready, req1_ready} == 2'b11, 0);
      if (rsp0_valid && rsp0_ready) begin
        if (exp0.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp0_unexpected actual=valid required=no_response t=%0t", $time);
        end else begin
          e = exp0.pop_front();
          check("rsp0_result", rsp0_result, e.res);
          check("rsp0_err", rsp0_err, e.err);
        end
      end
      if (rsp1_valid && rsp1_ready) begin
        if (exp1.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp1_unexpected actual=valid required=no_response t=%0t", $time);
        end else begin
          e = exp1.pop_front();
          check("rsp1_result", rsp1_result, e.res);
          check("rsp1_err", rsp1_err, e.err);
        end
      end
    end
  end

  initial begin
    int g_id[8];
    int g_cyc[8];
    int ng;
    int gcnt;
    logic [DATA_W-1:0] held;
    bit hs0, hs1;

    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_op = '0; req1_op = '0;
    req0_src1 = '0; req0_src2 = '0; req1_src1 = '0; req1_src2 = '0;

    do_reset();
    smp();
    check("reset_busy", busy, 0);
    check("reset_rsp0_valid", rsp0_valid, 0);
    check("reset_rsp1_valid", rsp1_valid, 0);
    check("reset_alu_op", alu_op, 0);
    check("reset_alu_src1", alu_src1, 0);
    check("reset_req0_ready", req0_ready, 0);

    // Single add on requester 0.
    step();
    req0_valid = 1; req0_op = 12'h001; req0_src1 = 5; req0_src2 = 7; rsp0_ready = 1;
    smp();
    check("add_req0_ready", req0_ready, 1);
    check("add_req1_ready", req1_ready, 0);
    step();
    req0_valid = 0; req0_op = 12'h002; req0_src1 = 99;
    smp();
    check("add_exec_alu_op", alu_op, 12'h001);
    check("add_exec_src1", alu_src1, 5);
    check("add_exec_src2", alu_src2, 7);
    check("add_exec_busy", busy, 1);
    check("add_exec_rsp0_valid", rsp0_valid, 0);
    step();
    smp();
    check("add_rsp0_valid", rsp0_valid, 1);
    check("add_rsp0_result", rsp0_result, 12);
    check("add_rsp1_valid", rsp1_valid, 0);
    check("add_resp_alu_op", alu_op, 0);
    step();
    smp();
    check("add_back_idle", busy, 0);

    // Illegal ops on requester 1: not one-hot, then zero.
    for (int k = 0; k < 2; k++) begin
      step();
      req1_valid = 1; req1_op = (k == 0) ? 12'h003 : 12'h000; req1_src1 = 9; req1_src2 = 9; rsp1_ready = 1;
      smp();
      check("ill_req1_ready", req1_ready, 1);
      step();
      req1_valid = 0;
      smp();
      check("ill_alu_op", alu_op, 0);
      check("ill_rsp1_valid", rsp1_valid, 1);
      check("ill_rsp1_err", rsp1_err, 1);
      check("ill_rsp1_result", rsp1_result, 0);
      check("ill_rsp0_valid", rsp0_valid, 0);
    end
    step();
    smp();
    check("ill_back_idle", busy, 0);

    // Round-robin tie with both requesters continuously valid.
    do_reset();
    req0_valid = 1; req0_op = 12'h002; req0_src1 = 3; req0_src2 = 5;
    req1_valid = 1; req1_op = 12'h001; req1_src1 = 1; req1_src2 = 1;
    rsp0_ready = 1; rsp1_ready = 1;
    ng = 0;
    for (int c = 0; c < 12; c++) begin
      smp();
      if ((req0_ready || req1_ready) && ng < 8) begin
        g_id[ng] = req1_ready ? 1 : 0;
        g_cyc[ng] = c;
        ng++;
      end
      step();
    end
    req0_valid = 0; req1_valid = 0;
    check("rr_grant_count", ng, 4);
    for (int i = 0; i < ng && i < 4; i++) begin
      check("rr_grant_id", g_id[i], i % 2);
      if (i > 0) check("rr_grant_gap", g_cyc[i] - g_cyc[i-1], 3);
    end
    repeat (3) step();

    // Backpressure on requester 0 while requester 1 waits.
    do_reset();
    req0_valid = 1; req0_op = 12'h004; req0_src1 = 32'hF0F0_1234; req0_src2 = 32'h0FF0_FFFF;
    rsp0_ready = 0; rsp1_ready = 1;
    smp();
    check("bp_req0_ready", req0_ready, 1);
    step();
    req0_valid = 0;
    req1_valid = 1; req1_op = 12'h001; req1_src1 = 10; req1_src2 = 20;
    smp();
    check("bp_exec_req1_ready", req1_ready, 0);
    step();
    held = 32'hF0F0_1234 & 32'h0FF0_FFFF;
    for (int c = 0; c < 4; c++) begin
      smp();
      check("bp_rsp0_valid", rsp0_valid, 1);
      check("bp_rsp0_stable", rsp0_result, held);
      check("bp_req1_ready", req1_ready, 0);
      check("bp_busy", busy, 1);
      step();
    end
    rsp0_ready = 1;
    smp();
    check("bp_release_valid", rsp0_valid, 1);
    step();
    smp();
    check("bp_req1_granted", req1_ready, 1);
    step();
    req1_valid = 0;
    repeat (3) step();

    // Reset asserted during EXEC.
    do_reset();
    req0_valid = 1; req0_op = 12'h001; req0_src1 = 40; req0_src2 = 2;
    rsp0_ready = 1; rsp1_ready = 1;
    smp();
    step();
    req0_valid = 0;
    smp();
    check("rst_in_exec", alu_op, 12'h001);
    #2 resetn = 0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_rsp0_valid", rsp0_valid, 0);
    check("rst_rsp1_valid", rsp1_valid, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_alu_src1", alu_src1, 0);
    req0_valid = 1; req0_op = 12'h008; req0_src1 = 32'h00F0; req0_src2 = 32'h0F00;
    req1_valid = 1; req1_op = 12'h010; req1_src1 = 32'hFFFF; req1_src2 = 32'h00FF;
    step();
    step();
    resetn = 1;
    smp();
    check("rst_tie_req0_ready", req0_ready, 1);
    check("rst_tie_req1_ready", req1_ready, 0);
    step();
    req0_valid = 0; req1_valid = 0;
    repeat (3) step();

    // Fixed priority instance: requester 0 always wins.
    do_reset();
    req0_valid = 1; req0_op = 12'h001; req0_src1 = 32'h1000; req0_src2 = 32'h0234;
    req1_valid = 1; req1_op = 12'h002; req1_src1 = 8; req1_src2 = 1;
    rsp0_ready = 1; rsp1_ready = 1;
    gcnt = 0;
    for (int c = 0; c < 30; c++) begin
      smp();
      if (b_req0_ready || b_req1_ready) begin
        gcnt++;
        check("fixed_grant_req1", b_req1_ready, 0);
      end
      if (b_rsp0_valid) check("fixed_rsp0_result", b_rsp0_result, 32'h1234);
      check("fixed_rsp1_valid", b_rsp1_valid, 0);
      step();
    end
    check("fixed_grant_count", gcnt, 10);
    req0_valid = 0; req1_valid = 0;
    repeat (3) step();

    // Randomized traffic against the scoreboard.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      smp();
      hs0 = req0_valid && req0_ready;
      hs1 = req1_valid && req1_ready;
      step();
      if (!req0_valid || hs0) begin
        req0_valid = ($urandom % 3) != 0;
        req0_op = rand_op(); req0_src1 = rand_data(); req0_src2 = rand_data();
      end
      if (!req1_valid || hs1) begin
        req1_valid = ($urandom % 3) != 0;
        req1_op = rand_op(); req1_src1 = rand_data(); req1_src2 = rand_data();
      end
      rsp0_ready = ($urandom % 4) != 0;
      rsp1_ready = ($urandom % 4) != 0;
    end
    req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
    repeat (6) step();
    smp();
    check("drain_exp0_empty", exp0.size(), 0);
    check("drain_exp1_empty", exp1.size(), 0);
    check("drain_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-requester arbiter and sequencer that time-shares the single 32-bit ALU of the execute datapath between two independent issue sources, e.g. the main execute stage and an address or branch helper. Each requester presents an ALU operation and operands over a valid/ready handshake. The block grants one request at a time, drives the shared ALU for one cycle, and registers the result. It then returns the result to the granted requester over a second valid/ready handshake. Operations that are not one-hot are rejected with an error flag and never reach the ALU.

## Interface
Parameters:
- RR_EN, 1: 1 = round-robin between requesters; 0 = fixed priority, requester 0 always wins.
- OP_W, 12: ALU operation vector width; one bit per operation.
- DATA_W, 32: operand and result width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op  in  OP_W  requester 0 ALU operation vector.
- req0_src1  in  DATA_W  requester 0 operand 1.
- req0_src2  in  DATA_W  requester 0 operand 2.
- rsp0_valid  out  1  result available for requester 0.
- rsp0_ready  in  1  requester 0 takes the result.
- rsp0_result  out  DATA_W  result for requester 0.
- rsp0_err  out  1  requester 0's operation was not one-hot.
- req1_* / rsp1_*  same as requester 0, for requester 1.
- alu_op  out  OP_W  to the shared ALU.
- alu_src1  out  DATA_W  to the shared ALU.
- alu_src2  out  DATA_W  to the shared ALU.
- alu_result  in  DATA_W  combinational result from the shared ALU.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, EXEC, RESP.
- IDLE: arbitrate among the asserted reqN_valid.
  - Exactly one requester valid: it is granted.
  - Both valid, RR_EN=1: grant the requester that is not last_grant.
  - Both valid, RR_EN=0: grant requester 0.
  - reqN_ready is high only for the granted requester, and only in IDLE.
- On acceptance, register op, src1, src2 and the grant ID, and update last_grant.
  - Op is one-hot (popcount == 1): go to EXEC.
  - Otherwise, including 0: go to RESP with result=0 and err=1.
- EXEC: drive alu_op/alu_src1/alu_src2 from the operand registers. Capture alu_result into the result register at the end of the cycle, set err=0, go to RESP.
- Outside EXEC: alu_op=0. alu_src1/alu_src2 keep the last registered operands.
- RESP:
  - rspN_valid=1 for the granted ID only; the other rsp valid stays 0.
  - rspN_result and rspN_err stay stable until rspN_valid & rspN_ready, then go to IDLE.
  - No new request is accepted in RESP.
- rspN_result/rspN_err reflect the result register whenever valid; they are don't-care otherwise and are driven 0.
- Requester inputs are sampled only at acceptance; changes afterwards have no effect.

## Timing
- Reset, asynchronous and immediate regardless of state:
  - State=IDLE, last_grant=1 (requester 0 wins the first tie).
  - Result register=0, err=0, operand registers=0.
  - All rsp*_valid=0, busy=0, alu_op=0.
  - Any in-flight operation is dropped silently.
- reqN_ready depends combinationally on state and both reqX_valid; there is no path from any ready back to a valid.
- Legal op:
  - Handshake at cycle T; EXEC at T+1; rspN_valid high from T+2.
  - With rspN_ready=1 at T+2, req_ready can assert again at T+3.
  - Minimum issue interval is 3 cycles.
- Illegal op:
  - Handshake at T; rspN_valid with err=1 from T+1.
  - Minimum interval is 2 cycles.
- Backpressure: rspN_ready low holds RESP indefinitely with result stable. The other requester stalls; no timeout.
- Round-robin tie: the same requester never gets two consecutive grants while both are continuously valid.

## Test plan
- Single add: req0 op=0x001, src1=5, src2=7 at T; alu_op=0x001 at T+1 only; rsp0_valid=1 and rsp0_result=12 at T+2; rsp1_valid stays 0.
- Tie, round-robin: both valid continuously with req0 sub (0x002, src1=3, src2=5) and req1 add (0x001, src1=1, src2=1), rsp_ready=1.
  - Grants go 0,1,0,1.
  - Results are 0xFFFFFFFE and 2.
  - Grants are spaced 3 cycles apart.
- Illegal op: req1 op=0x003 -> alu_op stays 0; rsp1_valid=1, rsp1_err=1, rsp1_result=0 one cycle after the handshake. op=0x000 gives the same response.
- Backpressure: rsp0_ready low for 4 cycles with req1_valid high -> rsp0_result stable, req1_ready=0 and busy=1 throughout; req1 is granted 1 cycle after the rsp0 handshake.
- Reset mid-EXEC: drop resetn during EXEC -> state IDLE, busy=0, no rsp_valid. After release with both requesters valid, requester 0 is granted.
- RR_EN=0: both requesters continuously valid -> requester 0 is granted every time; requester 1 is never granted.
